// File: rtl/mdu_hilo.sv
// HI/LO multiply-divide unit: 3-cycle MULT/MULTU, 33-cycle restoring DIV/DIVU, MTHI/MTLO writes.
// Latency: MTHI/MTLO at the start edge; MUL writes HI/LO at N+3, DIV at N+33. A start while busy is dropped.
module mdu_hilo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        hl_sel,
    output logic        busy,
    output logic        done,
    output logic [31:0] rhl_out
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state, state_nx;
    logic        accept, wr_en, sgn;
    logic [5:0]  cnt;
    logic [31:0] hi, lo, a_reg, b_reg, dvs, rem, quo;
    logic [31:0] rem_nx, quo_nx, res_hi, res_lo;
    logic [63:0] a_ext, b_ext, prod;
    logic [32:0] shifted, diff;
    logic        q_neg, r_neg;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        wr_en    = 1'b0;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state_nx = IDLE;
                    if (start) begin
                        accept = 1'b1;
                        case (op)
                            OP_MULT, OP_MULTU: state_nx = MUL;
                            OP_DIV, OP_DIVU:   state_nx = DIV;
                            default:           state_nx = IDLE;
                        endcase
                    end
                end
                MUL: if (cnt == 6'd2) begin
                    wr_en    = 1'b1;
                    state_nx = DONE;
                end
                DIV: if (cnt == 6'd32) begin
                    wr_en    = 1'b1;
                    state_nx = DONE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Low 64 bits of the sign/zero-extended product are exact for both signednesses.
    assign a_ext = {{32{sgn & a_reg[31]}}, a_reg};
    assign b_ext = {{32{sgn & b_reg[31]}}, b_reg};
    assign prod  = a_ext * b_ext;

    // One restoring step: diff[32] is the sign of the trial subtraction.
    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, dvs};
    assign rem_nx  = diff[32] ? shifted[31:0] : diff[31:0];
    assign quo_nx  = {quo[30:0], ~diff[32]};

    assign q_neg = sgn & (a_reg[31] ^ b_reg[31]);
    assign r_neg = sgn & a_reg[31];

    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (state == DIV) begin
            if (b_reg == 32'd0) begin
                res_hi = a_reg;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = r_neg ? -rem_nx : rem_nx;
                res_lo = q_neg ? -quo_nx : quo_nx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            hi    <= 32'd0;
            lo    <= 32'd0;
            a_reg <= 32'd0;
            b_reg <= 32'd0;
            dvs   <= 32'd0;
            rem   <= 32'd0;
            quo   <= 32'd0;
            cnt   <= 6'd0;
            sgn   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                if (op == OP_MTHI) hi <= a;
                if (op == OP_MTLO) lo <= a;
                if (!op[2]) begin
                    a_reg <= a;
                    b_reg <= b;
                    sgn   <= ~op[0];
                    cnt   <= 6'd0;
                end
            end else if (state == MUL || state == DIV) begin
                cnt <= cnt + 6'd1;
            end
            if (state == DIV) begin
                if (cnt == 6'd0) begin
                    dvs <= (sgn & b_reg[31]) ? -b_reg : b_reg;
                    quo <= (sgn & a_reg[31]) ? -a_reg : a_reg;
                    rem <= 32'd0;
                end else begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                end
            end
            if (wr_en) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

    assign busy    = (state == MUL) || (state == DIV);
    assign done    = (state == DONE);
    assign rhl_out = hl_sel ? hi : lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed and random checks of mdu_hilo against an arithmetic model of HI/LO.
module tb_mdu_hilo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        hl_sel = 1'b0;
    logic        busy, done;
    logic [31:0] rhl_out;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    mdu_hilo dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hl_sel(hl_sel), .busy(busy), .done(done), .rhl_out(rhl_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_hl(input string tag);
        hl_sel = 1'b1;
        #1 chk({tag, "_hi"}, rhl_out, hi_m);
        hl_sel = 1'b0;
        #1 chk({tag, "_lo"}, rhl_out, lo_m);
    endtask

    // Reference: HI/LO after an operation, from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        longint sa, sb, q, r;
        longint unsigned pu;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (o)
            3'd0: begin q = sa * sb; hi_m = q[63:32]; lo_m = q[31:0]; end
            3'd1: begin pu = {32'd0, av} * {32'd0, bv}; hi_m = pu[63:32]; lo_m = pu[31:0]; end
            3'd2, 3'd3: begin
                if (bv == 32'd0) begin
                    hi_m = av; lo_m = 32'hFFFF_FFFF;
                end else if (o == 3'd2) begin
                    q = sa / sb; r = sa % sb;
                    lo_m = q[31:0]; hi_m = r[31:0];
                end else begin
                    lo_m = av / bv; hi_m = av % bv;
                end
            end
            3'd4: hi_m = av;
            3'd5: lo_m = av;
            default: ;
        endcase
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input int flush_at, input bit inj, input bit done_mthi, input logic [31:0] mv);
        int lat, bcnt, dcnt;
        @(negedge clk);
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (o[2]) begin
            model(o, av, bv);
            chk("mt_busy", {31'd0, busy}, 32'd0);
            chk("mt_done", {31'd0, done}, 32'd0);
            chk_hl("mt");
            return;
        end
        lat  = (o < 3'd2) ? 3 : 33;
        bcnt = 0;
        dcnt = 0;
        for (int k = 0; k < lat; k++) begin
            if (busy) bcnt++;
            if (done) dcnt++;
            if (k == lat - 1) chk_hl("pre_write");
            if (inj && k == 5) begin
                op = 3'd4; a = 32'hAAAA_5555; start = 1'b1;
            end
            if (k == flush_at) flush = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            flush = 1'b0;
            if (k == flush_at) begin
                chk("flush_busy", {31'd0, busy}, 32'd0);
                chk("flush_done", {31'd0, done}, 32'd0);
                chk_hl("flush");
                @(posedge clk); #1;
                chk("flush_nodone", {31'd0, done}, 32'd0);
                return;
            end
        end
        chk("busy_cycles", bcnt, lat);
        chk("early_done", dcnt, 32'd0);
        model(o, av, bv);
        chk("res_busy", {31'd0, busy}, 32'd0);
        chk("res_done", {31'd0, done}, 32'd1);
        chk_hl("result");
        if (done_mthi) begin
            op = 3'd4; a = mv; start = 1'b1;
            model(3'd4, mv, 32'd0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_pulse", {31'd0, done}, 32'd0);
        if (done_mthi) chk_hl("done_mthi");
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk_hl("rst");
        #3 rst_n = 1'b1;

        do_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, -1, 1'b0, 1'b0, 32'd0);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, 1'b0, 32'd0);
        do_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, -1, 1'b0, 1'b0, 32'd0);
        do_op(3'd3, 32'h0000_0007, 32'h0000_0000, -1, 1'b0, 1'b0, 32'd0);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, 1'b0, 32'd0);
        do_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0000, -1, 1'b0, 1'b0, 32'd0);

        // MTHI while busy is dropped; MTHI in the DONE cycle is taken.
        do_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, -1, 1'b1, 1'b1, 32'h1357_9BDF);

        // Flush mid-divide, then MTLO.
        do_op(3'd4, 32'h1111_2222, 32'd0, -1, 1'b0, 1'b0, 32'd0);
        do_op(3'd3, 32'h0000_0064, 32'h0000_0007, 9, 1'b0, 1'b0, 32'd0);
        do_op(3'd5, 32'h0000_1234, 32'd0, -1, 1'b0, 1'b0, 32'd0);

        // Flush on the writing edge suppresses the write.
        do_op(3'd0, 32'h0000_0010, 32'h0000_0010, 2, 1'b0, 1'b0, 32'd0);
        do_op(3'd2, 32'h0000_0010, 32'h0000_0003, 32, 1'b0, 1'b0, 32'd0);

        // Flush and start on the same edge: start dropped.
        @(negedge clk);
        op = 3'd5; a = 32'hDEAD_BEEF; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("fs_busy", {31'd0, busy}, 32'd0);
        chk_hl("fs");
        @(negedge clk);
        op = 3'd0; a = 32'd5; b = 32'd5; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("fs_mul_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            do_op(ro, ra, rb, -1, 1'b0, 1'b0, 32'd0);
        end

        // Reset during MUL cycle 2, then a start on the first edge after release.
        @(negedge clk);
        op = 3'd0; a = 32'h0000_0007; b = 32'h0000_0009; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk_hl("arst");
        rst_n = 1'b1;
        do_op(3'd1, 32'h0001_0000, 32'h0001_0000, -1, 1'b0, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mdu_hilo.md
MDU_HILO -- requirements
Module: mdu_hilo

Interface
REQ-001 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, launches the operation given by op on the rising edge where it is sampled high.
REQ-004 SHALL have port op, input, 3, operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are no-ops.
REQ-005 SHALL have port a, input, 32, rs operand, already forwarded.
REQ-006 SHALL have port b, input, 32, rt operand, already forwarded.
REQ-007 SHALL have port flush, input, 1, aborts any in-flight operation.
REQ-008 SHALL have port hl_sel, input, 1, read select: 1 HI, 0 LO.
REQ-009 SHALL have port busy, output, 1, high while a MUL or DIV operation is in flight.
REQ-010 SHALL have port done, output, 1, one-cycle pulse on the cycle after HI/LO are updated by MUL or DIV.
REQ-011 SHALL have port rhl_out, output, 32, combinational read: HI if hl_sel is 1, else LO; this drives the RHLOut input of the write-back data mux.

Function
REQ-012 SHALL implement the states IDLE, MUL, DIV and DONE.
REQ-013 In IDLE, start with a MULT or MULTU op SHALL latch a and b and enter MUL; a DIV or DIVU op SHALL enter DIV.
REQ-014 In IDLE, start with MTHI SHALL write HI=a at that edge; MTLO SHALL write LO=a; neither SHALL assert busy or done.
REQ-015 Latency: with start sampled at edge N, HI/LO SHALL be written at edge N+3 for MUL and at edge N+33 for DIV (1 setup cycle plus 32 iterations).
REQ-016 busy SHALL be high from after edge N until after the edge at which HI/LO are written.
REQ-017 After HI/LO are written, the block SHALL be in DONE for one cycle with done=1 and busy=0, then return to IDLE.
REQ-018 A start arriving in DONE SHALL be accepted exactly as it would be in IDLE.
REQ-019 MULT SHALL be a signed 32x32->64 multiply, MULTU an unsigned one; result bits [63:32] go to HI and bits [31:0] to LO.
REQ-020 DIV/DIVU SHALL use a one-bit-per-cycle restoring divide on magnitudes; LO = quotient and HI = remainder.
REQ-021 For DIV, the quotient sign SHALL be a[31]^b[31] and the remainder SHALL take the sign of a.
REQ-022 For DIV, 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-023 For divide by zero (b=0, DIV or DIVU), the block SHALL still take full latency and SHALL give HI=a and LO=0xFFFFFFFF.
REQ-024 A start while busy=1 SHALL be ignored, including MTHI and MTLO.
REQ-025 flush=1 SHALL return the block to IDLE at the next edge, with HI/LO unchanged, busy=0 and no done pulse.
REQ-026 If flush and start are high at the same edge, flush SHALL win and the start SHALL be dropped.
REQ-027 If flush arrives on the same edge that would write HI/LO, the write SHALL be suppressed.
REQ-028 rhl_out SHALL reflect a HI/LO write in the cycle after the writing edge; there is no internal bypass.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously force: state IDLE, HI=0, LO=0, busy=0, done=0, and all operand and iteration registers to 0.
REQ-030 Reset asserted mid-operation SHALL discard the operation; after release, the block SHALL be idle and accept start on the first rising edge.

Verification
REQ-031 MULT with a=0xFFFFFFFE (-2) and b=0x00000003 -> HI=0xFFFFFFFF and LO=0xFFFFFFFA written at edge N+3, done pulses once, busy high for 3 cycles.
REQ-032 MULTU with a=b=0xFFFFFFFF -> HI=0xFFFFFFFE and LO=0x00000001.
REQ-033 DIV with a=0xFFFFFFF9 (-7) and b=2 -> LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1) at edge N+33; DIVU with a=7 and b=0 -> HI=7 and LO=0xFFFFFFFF.
REQ-034 DIVU launched, then flush at cycle 10 -> busy=0 next cycle, no done, HI/LO keep their prior values, and a following MTLO of 0x1234 reads back LO=0x1234.
REQ-035 start of MTHI at 0xAAAA5555 issued while a DIV is busy -> ignored, HI=DIV remainder afterwards; MTHI issued in the DONE cycle -> accepted.
REQ-036 rst_n pulsed low during MUL cycle 2 -> outputs 0 immediately, and a start right after release is accepted normally.
